// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl
// Single-master controller for the on-chip RAM. It takes one read or write
// request at a time over a valid/ready request channel, drives the RAM
// strobes for exactly one cycle, registers read data, and returns a
// response over a valid/ready response channel. Requests whose address is
// at or above DEPTH are rejected without touching the RAM. Rejections are
// counted in a saturating counter.
//
// Ports:
//   clk, rst_n            clock and asynchronous active-low reset
//   req_valid/req_ready   request handshake
//   req_we                1 = write, 0 = read
//   req_addr, req_wdata   request address and write data
//   rsp_valid/rsp_ready   response handshake
//   rsp_rdata             read data (0 for writes and rejected requests)
//   rsp_err               request was rejected (address out of range)
//   ram_data, ram_address RAM data input and address
//   ram_wren, ram_rden    RAM write / read strobes
//   ram_q                 RAM read data (valid only while ram_rden is high)
//   err_count             saturating count of rejected requests
module ram_access_ctrl #(
    parameter int DATA_W   = 14,
    parameter int ADDR_W   = 12,
    parameter int DEPTH    = 4096,
    parameter int ERRCNT_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic [DATA_W-1:0]   ram_data,
    output logic [ADDR_W-1:0]   ram_address,
    output logic                ram_wren,
    output logic                ram_rden,
    input  logic [DATA_W-1:0]   ram_q,
    output logic [ERRCNT_W-1:0] err_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // One extra bit so DEPTH == 2**ADDR_W is representable; in that case
    // the comparison can never be true and no address is rejected.
    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W+1)'(DEPTH);

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   addr_reg;
    logic [DATA_W-1:0]   wdata_reg;
    logic [DATA_W-1:0]   rdata_reg;
    logic                err_reg;
    logic [ERRCNT_W-1:0] err_count_reg;

    logic addr_oob;
    logic accept;
    logic rsp_done;

    assign addr_oob = ({1'b0, req_addr} >= DEPTH_EXT);
    assign accept   = (state_reg == IDLE) && req_valid;
    assign rsp_done = (state_reg == RESP) && rsp_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic. The write/read direction is carried by the state
    // itself, so the request's we bit needs no separate register.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    if (addr_oob)    state_next = RESP;
                    else if (req_we) state_next = WRITE;
                    else             state_next = READ;
                end
            end
            WRITE:   state_next = RESP;
            READ:    state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Latched request fields and response data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_reg      <= '0;
            wdata_reg     <= '0;
            rdata_reg     <= '0;
            err_reg       <= 1'b0;
            err_count_reg <= '0;
        end else begin
            // The address is only taken for in-range requests. A rejected
            // request never reaches the RAM, so ram_address keeps the last
            // address actually used.
            if (accept && !addr_oob) begin
                addr_reg  <= req_addr;
                wdata_reg <= req_we ? req_wdata : '0;
            end
            if (accept && addr_oob) begin
                err_reg <= 1'b1;
                if (err_count_reg != {ERRCNT_W{1'b1}}) begin
                    err_count_reg <= err_count_reg + 1'b1;
                end
            end
            // ram_q is only driven while the read strobe is high.
            if (state_reg == READ) begin
                rdata_reg <= ram_q;
            end
            if (rsp_done) begin
                rdata_reg <= '0;
                err_reg   <= 1'b0;
            end
        end
    end

    // Outputs decode from registered state and latched fields only.
    always_comb begin
        req_ready   = (state_reg == IDLE);
        rsp_valid   = (state_reg == RESP);
        ram_wren    = (state_reg == WRITE);
        ram_rden    = (state_reg == READ);
        ram_data    = (state_reg == WRITE) ? wdata_reg : '0;
        ram_address = addr_reg;
        rsp_rdata   = rdata_reg;
        rsp_err     = err_reg;
        err_count   = err_count_reg;
    end

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Directed bench for ram_access_ctrl, built with DEPTH=144 and ERRCNT_W=2
// so that range checking and counter saturation are reachable. A simple
// RAM model sits on the ram_* interface and a scoreboard array mirrors the
// words the bench expects the RAM to hold.
module tb_ram_access_ctrl;

    localparam int DATA_W   = 14;
    localparam int ADDR_W   = 12;
    localparam int DEPTH    = 144;
    localparam int ERRCNT_W = 2;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                req_valid = 1'b0;
    logic                req_ready;
    logic                req_we = 1'b0;
    logic [ADDR_W-1:0]   req_addr = '0;
    logic [DATA_W-1:0]   req_wdata = '0;
    logic                rsp_valid;
    logic                rsp_ready = 1'b0;
    logic [DATA_W-1:0]   rsp_rdata;
    logic                rsp_err;
    logic [DATA_W-1:0]   ram_data;
    logic [ADDR_W-1:0]   ram_address;
    logic                ram_wren;
    logic                ram_rden;
    wire  [DATA_W-1:0]   ram_q;
    logic [ERRCNT_W-1:0] err_count;

    int checks = 0;
    int errors = 0;

    // RAM model and scoreboard
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] sb  [0:DEPTH-1];

    int wren_cycles = 0;
    int rden_cycles = 0;
    int both_cycles = 0;
    int data_leaks  = 0;

    ram_access_ctrl #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .ERRCNT_W(ERRCNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .ram_data(ram_data), .ram_address(ram_address),
        .ram_wren(ram_wren), .ram_rden(ram_rden), .ram_q(ram_q),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    assign ram_q = ram_rden ? mem[ram_address] : 'z;

    always @(posedge clk) begin
        if (ram_wren) mem[ram_address] <= ram_data;
    end

    // Strobe activity observed mid-cycle
    always @(negedge clk) begin
        if (rst_n) begin
            if (ram_wren) wren_cycles++;
            if (ram_rden) rden_cycles++;
            if (ram_wren && ram_rden) both_cycles++;
            if (!ram_wren && ram_data != '0) data_leaks++;
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation time limit");
    end

    // One complete transaction. Inputs change 1 time unit after a rising
    // edge. cyc counts edges from acceptance through the response handshake.
    task automatic do_req(input logic we, input logic [ADDR_W-1:0] addr,
                          input logic [DATA_W-1:0] wd, input int stall,
                          output logic [DATA_W-1:0] rd, output logic er,
                          output int cyc);
        int n;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
        rsp_ready = (stall == 0);
        n = 0;
        while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        req_valid = 1'b0;
        cyc = 1;
        while (!rsp_valid && cyc < 50) begin @(posedge clk); #1; cyc++; end
        if (!rsp_valid) begin
            errors++;
            $display("FAIL rsp_timeout addr=%h", addr);
        end
        rd = rsp_rdata; er = rsp_err;
        for (int i = 0; i < stall; i++) begin @(posedge clk); #1; cyc++; end
        rsp_ready = 1'b1;
        @(posedge clk); #1; cyc++;
        rsp_ready = 1'b0;
        $display("txn we=%0b addr=%h wdata=%h rdata=%h err=%0b cycles=%0d",
                 we, addr, wd, rd, er, cyc);
    endtask

    task automatic test_reset();
        // in reset since time 0
        @(posedge clk); #1;
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== '0 ||
            rsp_err !== 1'b0 || ram_wren !== 1'b0 || ram_rden !== 1'b0 ||
            ram_data !== '0 || ram_address !== '0 || err_count !== '0) begin
            errors++;
            $display("FAIL reset_values got rdy=%b vld=%b rd=%h err=%b wr=%b rd=%b d=%h a=%h cnt=%h",
                     req_ready, rsp_valid, rsp_rdata, rsp_err, ram_wren, ram_rden,
                     ram_data, ram_address, err_count);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 12'h003; req_wdata = 14'h1234;
        @(posedge clk); #1;
        checks++;
        if (ram_wren !== 1'b1) begin
            errors++; $display("FAIL reset_prewrite ram_wren=%b want 1", ram_wren);
        end
        #2 rst_n = 1'b0;
        req_valid = 1'b0;
        #1;
        checks++;
        if (ram_wren !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b1 ||
            err_count !== '0 || ram_data !== '0) begin
            errors++;
            $display("FAIL reset_async wren=%b vld=%b rdy=%b cnt=%h data=%h want 0 0 1 0 0",
                     ram_wren, rsp_valid, req_ready, err_count, ram_data);
        end
        @(posedge clk); #1;
        checks++;
        if (mem[3] !== '0) begin
            errors++; $display("FAIL reset_write_dropped mem[3]=%h want 0", mem[3]);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        $display("test_reset done");
    endtask

    task automatic test_write_read();
        logic [DATA_W-1:0] rd; logic er; int cyc; int w0, r0;
        w0 = wren_cycles; r0 = rden_cycles;
        do_req(1'b1, 12'h005, 14'h2A5A, 0, rd, er, cyc);
        sb[5] = 14'h2A5A;
        checks++;
        if (wren_cycles - w0 != 1 || rden_cycles != r0) begin
            errors++; $display("FAIL write_strobe wren=%0d rden=%0d want 1 0",
                               wren_cycles - w0, rden_cycles - r0);
        end
        checks++;
        if (rd !== '0 || er !== 1'b0 || cyc != 3) begin
            errors++; $display("FAIL write_rsp rdata=%h err=%b cyc=%0d want 0 0 3", rd, er, cyc);
        end
        checks++;
        if (ram_address !== 12'h005) begin
            errors++; $display("FAIL addr_hold ram_address=%h want 005", ram_address);
        end
        w0 = wren_cycles;
        do_req(1'b0, 12'h005, 14'h0000, 0, rd, er, cyc);
        checks++;
        if (rd !== 14'h2A5A || er !== 1'b0 || cyc != 3) begin
            errors++; $display("FAIL read_rsp rdata=%h err=%b cyc=%0d want 2a5a 0 3", rd, er, cyc);
        end
        checks++;
        if (rden_cycles - r0 != 1 || wren_cycles != w0) begin
            errors++; $display("FAIL read_strobe rden=%0d wren=%0d want 1 0",
                               rden_cycles - r0, wren_cycles - w0);
        end
        checks++;
        if (rsp_rdata !== '0 || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL post_handshake rdata=%h vld=%b rdy=%b want 0 0 1",
                               rsp_rdata, rsp_valid, req_ready);
        end
    endtask

    task automatic test_back_pressure();
        int bad;
        bad = 0;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 12'h005; rsp_ready = 1'b0;
        @(posedge clk); #1;          // accepted, READ
        // keep a write request pending through the response phase
        req_we = 1'b1; req_addr = 12'h006; req_wdata = 14'h0777;
        @(posedge clk); #1;          // RESP
        for (int i = 0; i < 5; i++) begin
            if (rsp_valid !== 1'b1 || rsp_rdata !== 14'h2A5A || req_ready !== 1'b0 ||
                ram_wren !== 1'b0) bad++;
            @(posedge clk); #1;
        end
        checks++;
        if (bad != 0 || rsp_valid !== 1'b1) begin
            errors++; $display("FAIL stall_stable bad_cycles=%0d want 0", bad);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;          // handshake, back in IDLE
        rsp_ready = 1'b0;
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || ram_wren !== 1'b0) begin
            errors++; $display("FAIL held_req_ignored rdy=%b vld=%b wren=%b want 1 0 0",
                               req_ready, rsp_valid, ram_wren);
        end
        @(posedge clk); #1;          // held request accepted now
        req_valid = 1'b0;
        checks++;
        if (ram_wren !== 1'b1 || ram_address !== 12'h006 || ram_data !== 14'h0777) begin
            errors++; $display("FAIL held_req_accept wren=%b a=%h d=%h want 1 006 0777",
                               ram_wren, ram_address, ram_data);
        end
        sb[6] = 14'h0777;
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        $display("txn back_pressure done");
    endtask

    task automatic test_range();
        logic [DATA_W-1:0] rd; logic er; int cyc; int w0, r0;
        w0 = wren_cycles; r0 = rden_cycles;
        do_req(1'b1, 12'h090, 14'h1111, 0, rd, er, cyc);
        checks++;
        if (er !== 1'b1 || rd !== '0 || cyc != 2) begin
            errors++; $display("FAIL oob_rsp err=%b rdata=%h cyc=%0d want 1 0 2", er, rd, cyc);
        end
        checks++;
        if (wren_cycles != w0 || rden_cycles != r0 || err_count !== 2'd1) begin
            errors++; $display("FAIL oob_side wren=%0d rden=%0d cnt=%0d want 0 0 1",
                               wren_cycles - w0, rden_cycles - r0, err_count);
        end
        checks++;
        if (ram_address !== 12'h006) begin
            errors++; $display("FAIL oob_addr_hold ram_address=%h want 006", ram_address);
        end
        do_req(1'b1, 12'h08F, 14'h3ABC, 0, rd, er, cyc);
        sb[143] = 14'h3ABC;
        do_req(1'b0, 12'h08F, 14'h0000, 0, rd, er, cyc);
        checks++;
        if (er !== 1'b0 || rd !== 14'h3ABC || err_count !== 2'd1) begin
            errors++; $display("FAIL last_valid err=%b rdata=%h cnt=%0d want 0 3abc 1", er, rd, err_count);
        end
    endtask

    task automatic test_saturation();
        logic [DATA_W-1:0] rd; logic er; int cyc; int expv;
        rst_n = 1'b0;
        #2;
        checks++;
        if (err_count !== '0) begin
            errors++; $display("FAIL sat_reset cnt=%0d want 0", err_count);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            do_req(i[0], 12'hFFF - 12'(i), 14'h0001, 0, rd, er, cyc);
            expv = (i > 3) ? 3 : i;
            checks++;
            if (er !== 1'b1 || err_count !== 2'(expv)) begin
                errors++; $display("FAIL saturate step=%0d err=%b cnt=%0d want 1 %0d",
                                   i, er, err_count, expv);
            end
        end
    endtask

    task automatic test_random();
        logic [DATA_W-1:0] rd; logic er; int cyc;
        logic we; logic [ADDR_W-1:0] a; logic [DATA_W-1:0] wd; int stall;
        int bad_rd, bad_err, bad_cyc;
        bad_rd = 0; bad_err = 0; bad_cyc = 0;
        for (int i = 0; i < 1000; i++) begin
            we = 1'($urandom_range(0, 1));
            a = (($urandom_range(0, 19)) == 0) ? 12'($urandom_range(144, 4095))
                                                : 12'($urandom_range(0, 15));
            wd = 14'($urandom);
            stall = (($urandom_range(0, 7)) == 0) ? 2 : 0;
            do_req(we, a, wd, stall, rd, er, cyc);
            if (a >= 12'd144) begin
                if (er !== 1'b1 || rd !== '0 || cyc != 2 + stall) bad_err++;
            end else begin
                if (er !== 1'b0 || cyc != 3 + stall) bad_cyc++;
                if (we) begin
                    sb[a] = wd;
                    if (rd !== '0) bad_rd++;
                end else if (rd !== sb[a]) begin
                    bad_rd++;
                    $display("FAIL rand_read addr=%h got=%h want=%h", a, rd, sb[a]);
                end
            end
        end
        checks++;
        if (both_cycles != 0) begin
            errors++; $display("FAIL strobe_exclusive both_cycles=%0d want 0", both_cycles);
        end
        checks++;
        if (data_leaks != 0) begin
            errors++; $display("FAIL data_idle_zero leaks=%0d want 0", data_leaks);
        end
        checks++;
        if (bad_rd != 0) begin
            errors++; $display("FAIL rand_scoreboard bad=%0d want 0", bad_rd);
        end
        checks++;
        if (bad_err != 0 || bad_cyc != 0) begin
            errors++; $display("FAIL rand_rsp bad_err=%0d bad_cyc=%0d want 0 0", bad_err, bad_cyc);
        end
        checks++;
        if (err_count !== 2'd3) begin
            errors++; $display("FAIL rand_cnt cnt=%0d want 3", err_count);
        end
    endtask

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;
        for (int i = 0; i < DEPTH; i++) sb[i] = '0;
        test_reset();
        test_write_read();
        test_back_pressure();
        test_range();
        test_saturation();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
